// File: rtl/hdmi_text_axi_slave.sv
// hdmi_text_axi_slave: AXI4-Lite slave over the 600-word text VRAM and the colour register.
// Define VRAM_READBACK_EN to build the read channel; without it every read answers SLVERR.
module hdmi_text_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [9:0]                      mem_addr,
  output logic [31:0]                     mem_wdata,
  output logic [3:0]                      mem_we,
  output logic                            mem_en,
  input  logic [31:0]                     mem_rdata,
  output logic [31:0]                     ctrl
);
  localparam logic [9:0]  VRAM_WORDS = 10'd600;
  localparam logic [31:0] CTRL_RST   = 32'h01FF_E000;
  localparam logic [1:0]  OKAY       = 2'b00;
  localparam logic [1:0]  SLVERR     = 2'b10;

  logic        r_live, r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [9:0]  r_aw_idx;
  logic [31:0] r_wdata, r_ctrl;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp, r_rresp;
  logic        w_wr_go, w_wr_vram, w_rd_mem, w_ar_hs, w_unused;
  logic [9:0]  w_rd_idx;

  // r_live keeps every ready low until the first edge after reset release
  assign S_AXI_AWREADY = r_live & ~r_aw_held & ~r_bvalid;
  assign S_AXI_WREADY  = r_live & ~r_w_held & ~r_bvalid;
  assign w_wr_go       = r_aw_held & r_w_held;
  assign w_wr_vram     = w_wr_go & (r_aw_idx < VRAM_WORDS);
  assign w_ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;

  assign mem_en    = w_wr_vram | w_rd_mem;
  assign mem_we    = w_wr_vram ? r_wstrb : 4'h0;
  assign mem_addr  = w_wr_vram ? r_aw_idx : w_rd_mem ? w_rd_idx : 10'h0;
  assign mem_wdata = w_wr_vram ? r_wdata : 32'h0;

  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_BRESP  = r_bresp;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RRESP  = r_rresp;
  assign ctrl         = r_ctrl;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_ctrl    <= CTRL_RST;
    end else begin
      r_live <= 1'b1;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[11:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      if (w_wr_go) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= (r_aw_idx <= VRAM_WORDS) ? OKAY : SLVERR;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      if (w_wr_go && r_aw_idx == VRAM_WORDS)
        for (int i = 0; i < 4; i++)
          if (r_wstrb[i]) r_ctrl[8*i +: 8] <= r_wdata[8*i +: 8];
    end
  end

`ifdef VRAM_READBACK_EN
  logic        r_ar_pend, r_cap, w_rd_issue;
  logic [9:0]  r_ar_idx;
  logic [31:0] r_rdata;

  assign S_AXI_ARREADY = r_live & ~r_ar_pend & ~r_cap & ~r_rvalid;
  // a VRAM read yields the port to a coinciding write and issues one cycle later
  assign w_rd_issue    = r_ar_pend & ~(w_wr_vram & (r_ar_idx < VRAM_WORDS));
  assign w_rd_mem      = w_rd_issue & (r_ar_idx < VRAM_WORDS);
  assign w_rd_idx      = r_ar_idx;
  assign S_AXI_RDATA   = r_rdata;
  assign w_unused      = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ar_pend <= 1'b0;
      r_ar_idx  <= '0;
      r_cap     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      if (w_ar_hs) begin
        r_ar_pend <= 1'b1;
        r_ar_idx  <= S_AXI_ARADDR[11:2];
      end
      if (w_rd_issue) begin
        r_ar_pend <= 1'b0;
        r_cap     <= 1'b1;
      end
      if (r_cap) begin
        r_cap    <= 1'b0;
        r_rvalid <= 1'b1;
        r_rdata  <= (r_ar_idx < VRAM_WORDS) ? mem_rdata : (r_ar_idx == VRAM_WORDS) ? r_ctrl : 32'h0;
        r_rresp  <= (r_ar_idx <= VRAM_WORDS) ? OKAY : SLVERR;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end
`else
  assign S_AXI_ARREADY = r_live & ~r_rvalid;
  assign w_rd_mem      = 1'b0;
  assign w_rd_idx      = 10'h0;
  assign S_AXI_RDATA   = '0;
  assign w_unused      = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR, mem_rdata};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rresp  <= OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= SLVERR;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end
`endif
endmodule

// File: doc/hdmi_text_axi_slave.md
HDMI_TEXT_AXI_SLAVE -- requirements
Module: hdmi_text_axi_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, AXI byte-address width.
REQ-003 SHALL have S_AXI_ACLK  in  1  sole clock; one clock; all logic rising-edge.
REQ-004 SHALL have S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have S_AXI_AWADDR  in  12, S_AXI_AWVALID  in  1, S_AXI_AWREADY  out  1  (write address channel).
REQ-006 SHALL have S_AXI_WDATA  in  32, S_AXI_WSTRB  in  4, S_AXI_WVALID  in  1, S_AXI_WREADY  out  1  (write data channel).
REQ-007 SHALL have S_AXI_BRESP  out  2, S_AXI_BVALID  out  1, S_AXI_BREADY  in  1  (write response).
REQ-008 SHALL have S_AXI_ARADDR  in  12, S_AXI_ARVALID  in  1, S_AXI_ARREADY  out  1  (read address).
REQ-009 SHALL have S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID  out  1, S_AXI_RREADY  in  1  (read data).
REQ-010 SHALL have mem_addr  out  10, mem_wdata  out  32, mem_we  out  4, mem_en  out  1, mem_rdata  in  32  (VRAM port, 1-cycle read latency).
REQ-011 SHALL have ctrl  out  32  color register: fg R/G/B [24:21]/[20:17]/[16:13], bg R/G/B [12:9]/[8:5]/[4:1].

Function
REQ-012 SHALL decode word index = ADDR[11:2]; ADDR[1:0] ignored.
REQ-013 SHALL map index 0..599 to VRAM words, index 600 to ctrl, index 601..1023 to SLVERR (2'b10); valid accesses OKAY (2'b00).
REQ-014 SHALL accept AW and W independently: AWREADY high while no address held, WREADY high while no data held, no response pending.
REQ-015 SHALL, in the cycle after both AW and W are held, perform the write: VRAM -> mem_en=1, mem_we=WSTRB, mem_addr=index; ctrl -> byte lanes updated per WSTRB; SLVERR -> no state change.
REQ-016 SHALL assert BVALID the cycle after the write cycle and hold BVALID/BRESP stable until BREADY; AWREADY/WREADY low until B handshake completes.
REQ-017 SHALL give latency: AW+W handshake at cycle N -> mem_we at N+1 -> BVALID at N+2.
REQ-018 SHALL keep ARREADY high while idle with no read in progress; one outstanding read maximum.
REQ-019 SHALL, for a read handshake at N: mem_en=1, mem_we=0 at N+1; capture mem_rdata at N+2; RVALID with RDATA at N+3; ctrl/SLVERR reads return ctrl/32'h0 at same timing.
REQ-020 SHALL hold RVALID/RDATA/RRESP stable until RREADY.
REQ-021 SHALL give the write the VRAM port when read and write cycles coincide; the read issues the next cycle, shifting RVALID by one.
REQ-022 SHALL drive mem_we=0, mem_en=0 in all cycles with no access.

Reset
REQ-023 SHALL, with S_AXI_ARESETN low, force AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_en low; mem_we=0; BRESP, RRESP, RDATA, mem_addr, mem_wdata =0; ctrl=32'h01FF_E000 (white fg, black bg).
REQ-024 SHALL abandon any in-flight transaction on reset; no VRAM write after reset assertion; ready signals rise first cycle after release.

Configuration
REQ-025 SHALL compile the read channel only if VRAM_READBACK_EN is defined: with it REQ-018..021 apply; without it, ARREADY follows idle rule, RVALID at N+1 with RDATA=0, RRESP=SLVERR, mem_en never asserted for reads.

Verification
REQ-026 AW 0x000 + W 0x41424344 strobe 4'hF same cycle, BREADY=1 -> mem_we=4'hF, mem_addr=0 at N+1; BVALID, BRESP=00 at N+2.
REQ-027 W first, AW 0x960 three cycles later, WSTRB 4'b0010, WDATA 0x0000_AB00 -> ctrl=0x01FF_AB00, no mem_en, BRESP=00.
REQ-028 Write to 0x964 (index 601) -> BRESP=10, no mem_we, ctrl unchanged.
REQ-029 Read 0x004 with mem_rdata model 0xDEADBEEF, RREADY held low 5 cycles -> RVALID at N+3, RDATA stable 0xDEADBEEF until RREADY.
REQ-030 Read and write issuing VRAM access same cycle -> write at N+1, read mem_en at N+2, RVALID at N+4.
REQ-031 Assert S_AXI_ARESETN low between AW/W handshake and write cycle -> no mem_we, BVALID=0, ctrl=0x01FF_E000.
